pcie_fc_init_rx: RTL and testbench

Receive-side flow-control initialization engine for the PCIe data link layer. It consumes the DLLP AXI-stream from the link receive path, checks each DLLP's 16-bit CRC, and parses InitFC1, InitFC2 and UpdateFC DLLPs for VC0. It latches the partner's P/NP/Cpl header and data credit limits and raises the FI1/FI2 "values stored" flags consumed by the FC init transmitter.

---
 rtl/pcie_datalink_pkg.sv | 38 +++
 rtl/pcie_datalink_crc.sv | 21 ++
 rtl/pcie_fc_init_rx.sv | 141 ++++++++++++++
 tb/tb_pcie_fc_init_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pcie_datalink_pkg.sv
// pcie_datalink_pkg: shared DLLP types, VC0 constant, FC DLLP field layout and FC init FSM states
package pcie_datalink_pkg;
  typedef enum logic [3:0] {
    DLLP_ACK       = 4'h0,
    DLLP_NAK       = 4'h1,
    DLLP_INITFC1_P = 4'h4,
    DLLP_INITFC1_N = 4'h5,
    DLLP_INITFC1_C = 4'h6,
    DLLP_UPDFC_P   = 4'h8,
    DLLP_UPDFC_N   = 4'h9,
    DLLP_UPDFC_C   = 4'hA,
    DLLP_INITFC2_P = 4'hC,
    DLLP_INITFC2_N = 4'hD,
    DLLP_INITFC2_C = 4'hE
  } dllp_type_e;
  localparam logic [2:0] VC0       = 3'd0;
  localparam logic [1:0] GRP_INIT1 = 2'b01;
  localparam logic [1:0] GRP_UPD   = 2'b10;
  localparam logic [1:0] GRP_INIT2 = 2'b11;
  // Byte 0 sits in the low bits of the beat, so the struct lists byte3 first.
  typedef struct packed {
    logic [7:0] data_lo;
    logic [1:0] hdr_lo;
    logic [1:0] rsvd2;
    logic [3:0] data_hi;
    logic [1:0] rsvd1;
    logic [5:0] hdr_hi;
    logic [3:0] dtype;
    logic       rsvd0;
    logic [2:0] vc;
  } dllp_fc_t;
  typedef enum logic [1:0] {FC_IDLE, FC_FC1, FC_FC2, FC_DONE} fc_init_state_e;
  typedef enum logic {RX_HDR, RX_CRC} rx_state_e;
  // Type nibble [3:2] selects InitFC1/UpdateFC/InitFC2, [1:0] selects P/NP/Cpl; class 3 is not FC.
  function automatic logic is_fc(input logic [3:0] t);
    return t[3:2] != 2'b00 && t[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/pcie_datalink_crc.sv
// pcie_datalink_crc: DLLP CRC-16 (poly 0x100B) over 4 bytes, byte0 first, each byte LSB first
// Ports: crcIn seed, data 4 DLLP bytes (byte0 = data[7:0]), crcOut updated CRC (uninverted).
module pcie_datalink_crc (
  input  logic [15:0] crcIn,
  input  logic [31:0] data,
  output logic [15:0] crcOut
);
  logic [15:0] c;
  logic        fb;
  always_comb begin
    c  = crcIn;
    fb = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ data[8*b+i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
      end
    end
    crcOut = c;
  end
endmodule

// File: rtl/pcie_fc_init_rx.sv
// pcie_fc_init_rx: receive-side PCIe FC init engine; parses VC0 InitFC1/InitFC2/UpdateFC DLLPs and latches partner credits
// Ports: clk_i/rst_i (sync, active-low), fc_init_en_i (link up), s_axis_* DLLP stream (2 beats: bytes, CRC),
//        fc1/fc2_values_stored_o FI flags, {p,np,cpl}_{hdr,data}_fc_o latched credits, dllp_err_o error pulse.
// Config: define PCIE_FC_INIT_RX_CRC_CHECK_EN to compare the DLLP CRC; otherwise only framing is checked.
module pcie_fc_init_rx
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fc_init_en_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic                  fc1_values_stored_o,
  output logic                  fc2_values_stored_o,
  output logic [7:0]            p_hdr_fc_o,
  output logic [7:0]            np_hdr_fc_o,
  output logic [7:0]            cpl_hdr_fc_o,
  output logic [11:0]           p_data_fc_o,
  output logic [11:0]           np_data_fc_o,
  output logic [11:0]           cpl_data_fc_o,
  output logic                  dllp_err_o
);
  rx_state_e          rx_q, rx_d;
  fc_init_state_e     st_q, st_d;
  logic [31:0]        hdr_q, hdr_d;
  logic [2:0]         rec_q, rec_d;
  logic [2:0][7:0]    hfc_q, hfc_d;
  logic [2:0][11:0]   dfc_q, dfc_d;
  logic               fc1_q, fc1_d, fc2_q, fc2_d, err_q, err_d;
  logic               crc_ok, dllp_ok, good;
  logic [1:0]         grp, cls;
  dllp_fc_t           fc;
  logic               unused_ok;
`ifdef PCIE_FC_INIT_RX_CRC_CHECK_EN
  logic [15:0]        crc_out;
  pcie_datalink_crc u_crc (
    .crcIn  ('1),
    .data   (hdr_q),
    .crcOut (crc_out)
  );
  assign crc_ok = s_axis_tdata[15:0] == ~crc_out;
`else
  assign crc_ok = 1'b1;
`endif
  assign s_axis_tready = rst_i;
  assign fc   = dllp_fc_t'(hdr_q);
  assign grp  = fc.dtype[3:2];
  assign cls  = fc.dtype[1:0];
  assign good = dllp_ok && fc.vc == VC0 && is_fc(fc.dtype);
  assign unused_ok = ^{s_axis_tkeep, s_axis_tuser, fc.rsvd0, fc.rsvd1, fc.rsvd2};
  always_comb begin
    rx_d    = rx_q;
    hdr_d   = hdr_q;
    dllp_ok = 1'b0;
    err_d   = 1'b0;
    if (s_axis_tvalid) begin
      if (rx_q == RX_HDR) begin
        err_d = s_axis_tlast;
        hdr_d = s_axis_tlast ? hdr_q : s_axis_tdata;
        rx_d  = s_axis_tlast ? RX_HDR : RX_CRC;
      end else begin
        rx_d    = RX_HDR;
        dllp_ok = s_axis_tlast && crc_ok;
        err_d   = !dllp_ok;
      end
    end
    st_d  = st_q;
    rec_d = rec_q;
    hfc_d = hfc_q;
    dfc_d = dfc_q;
    fc1_d = fc1_q;
    fc2_d = fc2_q;
    case (st_q)
      FC_IDLE: st_d = FC_FC1;
      FC_FC1: begin
        if (good && (grp == GRP_INIT1 || grp == GRP_INIT2) && !rec_q[cls]) begin
          rec_d[cls] = 1'b1;
          hfc_d[cls] = {fc.hdr_hi, fc.hdr_lo};
          dfc_d[cls] = {fc.data_hi, fc.data_lo};
        end
        fc1_d = &rec_d;
        st_d  = &rec_d ? FC_FC2 : FC_FC1;
      end
      FC_FC2: begin
        fc2_d = good && (grp == GRP_INIT2 || grp == GRP_UPD);
        st_d  = fc2_d ? FC_DONE : FC_FC2;
      end
      default: st_d = FC_DONE;
    endcase
    if (!fc_init_en_i) begin
      rx_d  = RX_HDR;
      st_d  = FC_IDLE;
      err_d = 1'b0;
      rec_d = '0;
      hfc_d = '0;
      dfc_d = '0;
      fc1_d = 1'b0;
      fc2_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rx_q  <= RX_HDR;
      st_q  <= FC_IDLE;
      hdr_q <= '0;
      rec_q <= '0;
      hfc_q <= '0;
      dfc_q <= '0;
      fc1_q <= 1'b0;
      fc2_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rx_q  <= rx_d;
      st_q  <= st_d;
      hdr_q <= hdr_d;
      rec_q <= rec_d;
      hfc_q <= hfc_d;
      dfc_q <= dfc_d;
      fc1_q <= fc1_d;
      fc2_q <= fc2_d;
      err_q <= err_d;
    end
  end
  assign fc1_values_stored_o = fc1_q;
  assign fc2_values_stored_o = fc2_q;
  assign p_hdr_fc_o          = hfc_q[0];
  assign np_hdr_fc_o         = hfc_q[1];
  assign cpl_hdr_fc_o        = hfc_q[2];
  assign p_data_fc_o         = dfc_q[0];
  assign np_data_fc_o        = dfc_q[1];
  assign cpl_data_fc_o       = dfc_q[2];
  assign dllp_err_o          = err_q;
endmodule

// File: tb/tb_pcie_fc_init_rx.sv
// tb_pcie_fc_init_rx: directed table-driven bench for pcie_fc_init_rx
module tb_pcie_fc_init_rx;
`ifdef PCIE_FC_INIT_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_i, fc_init_en_i;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [2:0]  s_axis_tuser;
  logic        fc1_values_stored_o, fc2_values_stored_o, dllp_err_o;
  logic [7:0]  p_hdr_fc_o, np_hdr_fc_o, cpl_hdr_fc_o;
  logic [11:0] p_data_fc_o, np_data_fc_o, cpl_data_fc_o;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  pcie_fc_init_rx dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .fc_init_en_i        (fc_init_en_i),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tkeep        (s_axis_tkeep),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tuser        (s_axis_tuser),
    .s_axis_tready       (s_axis_tready),
    .fc1_values_stored_o (fc1_values_stored_o),
    .fc2_values_stored_o (fc2_values_stored_o),
    .p_hdr_fc_o          (p_hdr_fc_o),
    .np_hdr_fc_o         (np_hdr_fc_o),
    .cpl_hdr_fc_o        (cpl_hdr_fc_o),
    .p_data_fc_o         (p_data_fc_o),
    .np_data_fc_o        (np_data_fc_o),
    .cpl_data_fc_o       (cpl_data_fc_o),
    .dllp_err_o          (dllp_err_o)
  );
  logic [2:0]  st_act;
  logic [59:0] cr_act;
  assign st_act = {dllp_err_o, fc1_values_stored_o, fc2_values_stored_o};
  assign cr_act = {p_hdr_fc_o, np_hdr_fc_o, cpl_hdr_fc_o, p_data_fc_o, np_data_fc_o, cpl_data_fc_o};
  typedef struct {
    logic [3:0]  t;
    logic [2:0]  vc;
    logic [7:0]  hdr;
    logic [11:0] dat;
    logic        bad;
    logic [2:0]  exp_st;
    logic [59:0] exp_cr;
  } vec_t;
  vec_t vec[9];
  function automatic logic [59:0] cr(input logic [7:0] ph, nh, ch, input logic [11:0] pd, nd, cd);
    return {ph, nh, ch, pd, nd, cd};
  endfunction
  function automatic logic [15:0] crc_of(input logic [31:0] w);
    logic [15:0] c = 16'hFFFF;
    logic        fb;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ w[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    return c;
  endfunction
  function automatic logic [31:0] mkw(input logic [3:0] t, input logic [2:0] vc, input logic [7:0] hdr, input logic [11:0] dat);
    return {dat[7:0], hdr[1:0], 2'b00, dat[11:8], 2'b00, hdr[7:2], t, 1'b0, vc};
  endfunction
  function automatic logic [31:0] crcw(input logic [31:0] w, input logic bad);
    return {16'h0000, ~crc_of(w) ^ {15'h0000, bad}};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic beat(input logic [31:0] w, input logic last);
    s_axis_tdata  = w;
    s_axis_tkeep  = last ? 4'h3 : 4'hF;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
  endtask
  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask
  task automatic send(input logic [3:0] t, input logic [2:0] vc, input logic [7:0] hdr, input logic [11:0] dat, input logic bad);
    logic [31:0] w = mkw(t, vc, hdr, dat);
    beat(w, 1'b0);
    beat(crcw(w, bad), 1'b1);
    idle();
  endtask
  initial begin
    logic [59:0] c0, c3, c5;
    logic [31:0] wp, wn, wc;
    c0 = cr(CRC_EN ? 8'h00 : 8'h20, 8'h00, 8'h00, CRC_EN ? 12'h000 : 12'h010, 12'h000, 12'h000);
    c3 = cr(CRC_EN ? 8'h00 : 8'h20, 8'h20, 8'h00, CRC_EN ? 12'h000 : 12'h010, 12'h020, 12'h000);
    c5 = cr(8'h20, 8'h20, 8'h00, 12'h010, 12'h020, 12'h000);
    vec[0] = '{4'h4, 3'd0, 8'h20, 12'h010, 1'b1, {CRC_EN, 2'b00}, c0};
    vec[1] = '{4'h4, 3'd1, 8'h33, 12'h033, 1'b0, 3'b000, c0};
    vec[2] = '{4'h0, 3'd0, 8'h00, 12'h000, 1'b0, 3'b000, c0};
    vec[3] = '{4'h5, 3'd0, 8'h20, 12'h020, 1'b0, 3'b000, c3};
    vec[4] = '{4'h6, 3'd0, 8'h00, 12'h000, 1'b0, {1'b0, !CRC_EN, 1'b0}, c3};
    vec[5] = '{4'h4, 3'd0, 8'h20, 12'h010, 1'b0, 3'b010, c5};
    vec[6] = '{4'h4, 3'd0, 8'h40, 12'h040, 1'b0, 3'b010, c5};
    vec[7] = '{4'hC, 3'd0, 8'h55, 12'h155, 1'b0, 3'b011, c5};
    vec[8] = '{4'h9, 3'd0, 8'h77, 12'h177, 1'b0, 3'b011, c5};
    rst_i = 1'b0;
    fc_init_en_i = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tuser = '0;
    idle();
    repeat (3) @(negedge clk);
    chk("reset_tready", 64'(s_axis_tready), 64'h0);
    chk("reset_status", 64'(st_act), 64'h0);
    chk("reset_credits", 64'(cr_act), 64'h0);
    rst_i = 1'b1;
    fc_init_en_i = 1'b1;
    @(negedge clk);
    chk("tready_run", 64'(s_axis_tready), 64'h1);
    for (int i = 0; i < 9; i++) begin
      send(vec[i].t, vec[i].vc, vec[i].hdr, vec[i].dat, vec[i].bad);
      chk($sformatf("vec%0d_status", i), 64'(st_act), 64'(vec[i].exp_st));
      chk($sformatf("vec%0d_credits", i), 64'(cr_act), 64'(vec[i].exp_cr));
    end
    beat(32'h0000_0004, 1'b1);
    idle();
    chk("single_beat_err", 64'(st_act), 64'h7);
    @(negedge clk);
    chk("err_one_cycle", 64'(st_act), 64'h3);
    fc_init_en_i = 1'b0;
    @(negedge clk);
    chk("disable_status", 64'(st_act), 64'h0);
    chk("disable_credits", 64'(cr_act), 64'h0);
    fc_init_en_i = 1'b1;
    @(negedge clk);
    send(4'hD, 3'd0, 8'h20, 12'h020, 1'b0);
    chk("early_fc2_np", 64'(cr_act), 64'(cr(8'h00, 8'h20, 8'h00, 12'h000, 12'h020, 12'h000)));
    send(4'h5, 3'd0, 8'h40, 12'h040, 1'b0);
    chk("repeat_np_ignored", 64'(cr_act), 64'(cr(8'h00, 8'h20, 8'h00, 12'h000, 12'h020, 12'h000)));
    chk("partial_no_fi1", 64'(st_act), 64'h0);
    fc_init_en_i = 1'b0;
    @(negedge clk);
    chk("abort_status", 64'(st_act), 64'h0);
    chk("abort_credits", 64'(cr_act), 64'h0);
    fc_init_en_i = 1'b1;
    @(negedge clk);
    wp = mkw(4'h4, 3'd0, 8'h20, 12'h010);
    wn = mkw(4'h5, 3'd0, 8'h20, 12'h020);
    wc = mkw(4'hE, 3'd0, 8'h00, 12'h000);
    beat(wp, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    beat(crcw(wp, 1'b0), 1'b1);
    beat(wn, 1'b0);
    beat(crcw(wn, 1'b0), 1'b1);
    beat(wc, 1'b0);
    beat(crcw(wc, 1'b0), 1'b1);
    idle();
    chk("replay_fi1_not_fi2", 64'(st_act), 64'h2);
    chk("replay_credits", 64'(cr_act), 64'(c5));
    send(4'h9, 3'd0, 8'h11, 12'h111, 1'b0);
    chk("updfc_sets_fi2", 64'(st_act), 64'h3);
    chk("fi2_credits_hold", 64'(cr_act), 64'(c5));
    beat(wp, 1'b0);
    rst_i = 1'b0;
    idle();
    @(negedge clk);
    chk("midreset_tready", 64'(s_axis_tready), 64'h0);
    chk("midreset_status", 64'(st_act), 64'h0);
    chk("midreset_credits", 64'(cr_act), 64'h0);
    rst_i = 1'b1;
    @(negedge clk);
    beat(crcw(wp, 1'b0), 1'b1);
    idle();
    chk("midreset_discard", 64'(st_act), 64'h4);
    chk("midreset_nolatch", 64'(cr_act), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
